divisor_secuencial_4b: RTL and testbench
========================================

# divisor_secuencial_4b

Sequential restoring divider that computes quotient and remainder of two unsigned operands, one quotient bit per clock. It sits directly downstream of the numerator/denominator entry counters and upstream of the 4-to-1 LED display mux. It replaces the constant `result`/`rest` placeholders of the divider top level. The top level pulses `start` when the selector advances from the denominator-entry step to the result step.

## Interface
Parameters:
- `WIDTH`, default 4: operand, quotient and remainder width.

Ports:
- `clk`  in  1: system clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `start`  in  1: single-cycle request; sampled only in IDLE.
- `num`  in  WIDTH: dividend, unsigned.
- `den`  in  WIDTH: divisor, unsigned.
- `busy`  out  1: high while iterating (CALC).
- `done`  out  1: high for exactly one cycle when outputs update.
- `div_zero`  out  1: high if the last completed operation had `den == 0`; held until the next completion.
- `result`  out  WIDTH: quotient; held until the next completion.
- `rest`  out  WIDTH: remainder; held until the next completion.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE**:
  - If `start=1` and `den!=0`: latch `num` into the quotient shift register Q, latch `den` into D, clear the partial remainder R (WIDTH+1 bits) and the iteration counter, then go to CALC.
  - If `start=1` and `den==0`: load `result`=all ones, `rest=num`, `div_zero=1`, then go to DONE.
  - If `start=0`: stay in IDLE.
- **CALC**, one iteration per edge:
  - Form {R,Q} shifted left by 1 and compute T = R_shifted − {0,D}.
  - If T is non-negative (MSB 0): R←T and Q[0]←1.
  - Otherwise: R←R_shifted and Q[0]←0.
  - Increment the counter.
  - On the edge performing iteration WIDTH: load `result` from final Q, `rest` from final R[WIDTH-1:0], `div_zero=0`, and go to DONE.
- **DONE**: `done=1`; the next edge returns to IDLE unconditionally.
- `start` outside IDLE is ignored. It is neither queued nor a restart.
- `num`/`den` are sampled only at the start edge. Later changes do not affect an operation in progress.
- Arithmetic is unsigned throughout. The invariant `num = result*den + rest` with `rest < den` holds for `den != 0`.
- Asserting `rst` mid-operation aborts immediately: state goes to IDLE and all outputs reset. There is no completion pulse.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `div_zero=0`, `result=0`, `rest=0`. Internal R, Q, D and the counter are 0.
- Start accepted at edge k, `den!=0`:
  - `busy=1` after edges k … k+WIDTH−1.
  - After edge k+WIDTH: `busy=0`, `done=1`, outputs valid.
  - After edge k+WIDTH+1: `done=0` and the block is back in IDLE.
  - Latency is WIDTH cycles from the accepting edge to valid outputs: 4 for the default.
- Divide by zero, start at edge k: `done=1` and the outputs valid after edge k. `busy` never rises.
- Minimum start-to-start spacing: WIDTH+2 cycles normally, 2 cycles on divide by zero.
- `busy` and `done` are never high together.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package/include holds:
  - the state encoding localparams `ST_IDLE=2'd0`, `ST_CALC=2'd1`, `ST_DONE=2'd2`;
  - the default `WIDTH` constant.
- One natural sub-module, `paso_division`: combinational single iteration, {R,Q,D} → {R',Q'}. It is instantiated once and reused each cycle.
- Top-level integration:
  - drive `start` from the rising transition of `sel` into 2'b10;
  - connect `result`/`rest` to mux inputs d2/d3.

## Test plan
- Reset then `num=13`, `den=3`, one-cycle `start` -> exactly 4 busy cycles, then `done` for 1 cycle with `result=4`, `rest=1`, `div_zero=0`.
- `num=15`, `den=1` -> `result=15`, `rest=0`. Then `num=2`, `den=7` -> `result=0`, `rest=2`. Previous values hold between operations.
- `num=5`, `den=0` -> `done` on the cycle after the start edge, `result=15`, `rest=5`, `div_zero=1`, `busy` never high.
- During CALC of 9/2: pulse `start` with 14/3 and change `num`/`den` -> ignored; outputs `result=4`, `rest=1` at the normal cycle.
- `rst` low for one cycle during the second CALC cycle -> all outputs 0 and IDLE immediately, no `done`. A subsequent 12/5 yields `result=2`, `rest=2`.
- Exhaustive sweep of all 256 num/den pairs -> the invariant holds for every `den!=0`, and the div-zero response matches for every `den=0`.

Source files
------------

// File: rtl/divisor_secuencial_4b_pkg.sv
// rtl/divisor_secuencial_4b_pkg.sv - shared constants for the sequential divider
// State encoding and default operand width used by the divider and its step logic.
package divisor_secuencial_4b_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/divisor_secuencial_4b_paso_division.sv
// rtl/divisor_secuencial_4b_paso_division.sv - one restoring-division iteration
// Combinational step {R,Q,D} -> {R',Q'}; the top reuses a single instance every cycle.
module paso_division
  import divisor_secuencial_4b_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH:0]   r_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0]   r_sh;
  logic [WIDTH+1:0] t;
  logic             neg;
  logic             unused_r_msb;

  // R stays below D, so its top bit is always zero once shifted out.
  assign unused_r_msb = r_in[WIDTH];

  always_comb begin
    r_sh  = {r_in[WIDTH-1:0], q_in[WIDTH-1]};
    t     = {1'b0, r_sh} - {2'b00, d_in};
    neg   = t[WIDTH+1];
    r_out = neg ? r_sh : t[WIDTH:0];
    q_out = {q_in[WIDTH-2:0], ~neg};
  end

endmodule

// File: rtl/divisor_secuencial_4b.sv
// rtl/divisor_secuencial_4b.sv - sequential restoring divider, one quotient bit per clock
// IDLE -> CALC (WIDTH iterations) -> DONE; divide-by-zero goes straight to DONE.
module divisor_secuencial_4b
  import divisor_secuencial_4b_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] rest
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rest_q, rest_d;

  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;

  paso_division #(.WIDTH(WIDTH)) u_paso (
    .r_in  (r_q),
    .q_in  (q_q),
    .d_in  (d_q),
    .r_out (r_step),
    .q_out (q_step)
  );

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    q_d        = q_q;
    d_d        = d_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    result_d   = result_q;
    rest_d     = rest_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (den != '0) begin
            q_d     = num;
            d_d     = den;
            r_d     = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = S_CALC;
          end else begin
            result_d   = {WIDTH{1'b1}};
            rest_d     = num;
            div_zero_d = 1'b1;
            done_d     = 1'b1;
            state_d    = S_DONE;
          end
        end
      end
      S_CALC: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + CW'(1);
        // Last iteration: publish results on the same edge that leaves CALC.
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d   = q_step;
          rest_d     = r_step[WIDTH-1:0];
          div_zero_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      r_q        <= '0;
      q_q        <= '0;
      d_q        <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      result_q   <= '0;
      rest_q     <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      q_q        <= q_d;
      d_q        <= d_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      result_q   <= result_d;
      rest_q     <= rest_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign result   = result_q;
  assign rest     = rest_q;

endmodule

// File: tb/tb_divisor_secuencial_4b.sv
// tb/tb_divisor_secuencial_4b.sv - self-checking bench for divisor_secuencial_4b
// Arithmetic reference model checked every cycle, plus literal expectations per directed case.
module tb_divisor_secuencial_4b;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] num = '0;
  logic [W-1:0] den = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] result, rest;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // reference model state
  bit  m_busy = 0, m_done = 0, m_dz = 0;
  int  m_res = 0, m_rest = 0;
  int  p_res = 0, p_rest = 0;
  int  m_left = 0;

  divisor_secuencial_4b #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num      (num),
    .den      (den),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .result   (result),
    .rest     (rest)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_dz = 0; m_res = 0; m_rest = 0; m_left = 0;
  endtask

  always @(negedge rst) model_reset();

  always @(posedge clk) begin
    if (!rst) begin
      model_reset();
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1; m_dz = 0; m_res = p_res; m_rest = p_rest;
      end
    end else if (start) begin
      if (den != 0) begin
        p_res  = int'(num) / int'(den);
        p_rest = int'(num) % int'(den);
        m_busy = 1;
        m_left = W;
      end else begin
        m_done = 1; m_dz = 1; m_res = (1 << W) - 1; m_rest = int'(num);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", int'(busy), int'(m_busy));
      check("done", int'(done), int'(m_done));
      check("div_zero", int'(div_zero), int'(m_dz));
      check("result", int'(result), m_res);
      check("rest", int'(rest), m_rest);
      check("busy_and_done", int'(busy & done), 0);
    end
  end

  task automatic issue(input int n, input int d);
    @(posedge clk); #2;
    num = W'(n); den = W'(d); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  // Waits at negedges for done; reports negedges taken and busy cycles seen.
  task automatic wait_done(output int waited, output int busy_cnt);
    waited = 0; busy_cnt = 0;
    while (waited < 20) begin
      @(negedge clk);
      waited++;
      if (busy) busy_cnt++;
      if (done) break;
    end
    if (!done) begin
      errors++;
      $display("FAIL wait_done: no done within 20 cycles at %0t", $time);
    end
  endtask

  task automatic expect_out(input string name, input int r, input int s, input int dz);
    check({name, "_result"}, int'(result), r);
    check({name, "_rest"}, int'(rest), s);
    check({name, "_div_zero"}, int'(div_zero), dz);
    check({name, "_model_result"}, m_res, r);
    check({name, "_model_rest"}, m_rest, s);
  endtask

  initial begin
    int wt, bc;
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_rest", int'(rest), 0);
    check("rst_div_zero", int'(div_zero), 0);
    @(posedge clk); #2;
    rst = 1'b1;
    cmp_en = 1'b1;

    issue(13, 3);
    wait_done(wt, bc);
    check("13_3_busy_cycles", bc, 4);
    check("13_3_latency", wt, 5);
    expect_out("13_3", 4, 1, 0);

    issue(15, 1);
    wait_done(wt, bc);
    expect_out("15_1", 15, 0, 0);
    repeat (3) @(negedge clk);
    expect_out("15_1_hold", 15, 0, 0);

    issue(2, 7);
    wait_done(wt, bc);
    expect_out("2_7", 0, 2, 0);

    issue(5, 0);
    wait_done(wt, bc);
    check("5_0_latency", wt, 1);
    check("5_0_busy_cycles", bc, 0);
    expect_out("5_0", 15, 5, 1);

    // start during CALC must be ignored, as must input changes
    issue(9, 2);
    @(posedge clk); #2;
    num = 4'd14; den = 4'd3; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; num = 4'd0; den = 4'd0;
    wait_done(wt, bc);
    expect_out("9_2_ignore", 4, 1, 0);
    repeat (3) @(negedge clk);
    check("ignore_no_restart", int'(busy), 0);

    // abort with reset during the second CALC cycle
    issue(9, 2);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_result", int'(result), 0);
    check("abort_rest", int'(rest), 0);
    @(posedge clk); #2;
    rst = 1'b1;
    bc = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) bc++;
    end
    check("abort_no_done", bc, 0);

    issue(12, 5);
    wait_done(wt, bc);
    expect_out("12_5", 2, 2, 0);

    for (int n = 0; n < 16; n++) begin
      for (int d = 0; d < 16; d++) begin
        issue(n, d);
        wait_done(wt, bc);
        if (d != 0) begin
          check("sweep_invariant", int'(result) * d + int'(rest), n);
          check("sweep_rest_lt_den", int'(int'(rest) < d), 1);
        end else begin
          check("sweep_dz_result", int'(result), 15);
          check("sweep_dz_rest", int'(rest), n);
          check("sweep_dz_flag", int'(div_zero), 1);
        end
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
